// File: rtl/ieeedrv_rom_arb.sv
// ieeedrv_rom_arb: round-robin arbiter that shares one single-port ROM among
// up to four drive read requesters, with an optional ROM download (write) path.
// Optional feature macro: IEEEDRV_ROM_LOAD_EN enables the load_* write path.
// Without it, the load inputs are ignored, rom_wren/rom_data are tied to 0,
// and load_active does not block reads.
//
// Requester handshake: a requester raises drv_req and holds drv_req/drv_addr
// stable until it sees a one-cycle drv_ack. drv_data is valid in that ack cycle
// and stays valid until the next ack to the same requester. A requester that
// keeps drv_req high through its ack cycle starts a new read with the address
// it presents at that time.
module ieeedrv_rom_arb #(
  parameter int NDR       = 4,
  parameter int ADDRWIDTH = 14,
  parameter int RD_LAT    = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NDR-1:0]                 drv_req,
  input  logic [NDR-1:0][ADDRWIDTH-1:0]  drv_addr,
  output logic [NDR-1:0]                 drv_ack,
  output logic [NDR-1:0][7:0]            drv_data,
  input  logic                           load_active,
  input  logic                           load_wr,
  input  logic [ADDRWIDTH-1:0]           load_addr,
  input  logic [7:0]                     load_data,
  output logic [ADDRWIDTH-1:0]           rom_addr,
  output logic [7:0]                     rom_data,
  output logic                           rom_wren,
  input  logic [7:0]                     rom_q
);

  localparam int IDW = (NDR > 1) ? $clog2(NDR) : 1;

  logic [NDR-1:0]             pending;
  logic [NDR-1:0]             elig;
  logic [NDR-1:0]             grant_mask;
  logic [NDR-1:0]             ret_mask;
  logic [IDW-1:0]             rr_ptr;
  logic [IDW-1:0]             win_id;
  logic [IDW-1:0]             cand;
  logic                       win_vld;
  // Tag pipeline: stage k holds the read granted k+1 edges ago.
  logic [RD_LAT:0]            tag_v;
  logic [RD_LAT:0][IDW-1:0]   tag_id;
  logic                       load_blk;
  logic                       wr_fire;

`ifdef IEEEDRV_ROM_LOAD_EN
  assign load_blk = load_active;
  assign wr_fire  = load_active & load_wr;

  // Download write port: one-cycle write enable, data held after the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_wren <= 1'b0;
      rom_data <= '0;
    end else begin
      rom_wren <= wr_fire;
      if (wr_fire) rom_data <= load_data;
    end
  end
`else
  logic unused_load;
  assign unused_load = ^{load_active, load_wr, load_data};
  assign load_blk    = 1'b0;
  assign wr_fire     = 1'b0;
  assign rom_wren    = 1'b0;
  assign rom_data    = '0;
`endif

  // A requester may compete only while idle, not in its ack cycle, and not
  // while a download owns the ROM.
  assign elig = drv_req & ~pending & ~drv_ack & {NDR{~load_blk}};

  // Round-robin pick: scan from the requester after the last winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = rr_ptr;
    for (int k = 0; k < NDR; k++) begin
      cand = (cand == IDW'(NDR - 1)) ? '0 : cand + 1'b1;
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // One-hot views of the new grant and of the read returning this edge.
  always_comb begin
    grant_mask = '0;
    ret_mask   = '0;
    if (win_vld)        grant_mask[win_id]         = 1'b1;
    if (tag_v[RD_LAT])  ret_mask[tag_id[RD_LAT]]   = 1'b1;
  end

  // Grant bookkeeping, ROM address mux, tag pipeline and read-data return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= IDW'(NDR - 1);
      pending  <= '0;
      tag_v    <= '0;
      tag_id   <= '0;
      drv_ack  <= '0;
      drv_data <= '0;
      rom_addr <= '0;
    end else begin
      tag_v   <= {tag_v[RD_LAT-1:0], win_vld};
      tag_id  <= {tag_id[RD_LAT-1:0], win_id};
      pending <= (pending & ~ret_mask) | grant_mask;
      drv_ack <= ret_mask;
      for (int i = 0; i < NDR; i++) begin
        if (ret_mask[i]) drv_data[i] <= rom_q;
      end
      if (win_vld) rr_ptr <= win_id;
      // A write and a grant never coincide: writes only happen while reads are blocked.
      if (wr_fire)      rom_addr <= load_addr;
      else if (win_vld) rom_addr <= drv_addr[win_id];
    end
  end

endmodule

// File: tb/tb_ieeedrv_rom_arb.sv
// Testbench for ieeedrv_rom_arb: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a transaction-level
// model (eligibility, round-robin choice, ack scheduled RD_LAT+1 edges later).
module tb_ieeedrv_rom_arb;
  localparam int NDR    = 4;
  localparam int AW     = 14;
  localparam int RD_LAT = 2;
`ifdef IEEEDRV_ROM_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDR-1:0]          drv_req;
  logic [NDR-1:0][AW-1:0]  drv_addr;
  logic [NDR-1:0]          drv_ack;
  logic [NDR-1:0][7:0]     drv_data;
  logic                    load_active;
  logic                    load_wr;
  logic [AW-1:0]           load_addr;
  logic [7:0]              load_data;
  logic [AW-1:0]           rom_addr;
  logic [7:0]              rom_data;
  logic                    rom_wren;
  logic [7:0]              rom_q;

  ieeedrv_rom_arb #(.NDR(NDR), .ADDRWIDTH(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .drv_req(drv_req), .drv_addr(drv_addr),
    .drv_ack(drv_ack), .drv_data(drv_data),
    .load_active(load_active), .load_wr(load_wr),
    .load_addr(load_addr), .load_data(load_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_wren(rom_wren), .rom_q(rom_q)
  );

  // ---------------- ROM model (RD_LAT edges address -> data) ----------------
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] qp  [0:RD_LAT-1];
  assign rom_q = qp[RD_LAT-1];

  function automatic logic [7:0] rom_init(input int a);
    return 8'((a * 37) + (a >> 7));
  endfunction

  always @(posedge clk) begin
    if (rom_wren) mem[rom_addr] <= rom_data;
    qp[0] <= mem[rom_addr];
    for (int k = 1; k < RD_LAT; k++) qp[k] <= qp[k-1];
  end

  // ---------------- behavioural reference model ----------------
  logic [NDR-1:0]       m_pend, m_ack, m_el;
  logic [NDR-1:0][7:0]  m_data;
  logic [AW-1:0]        m_addr;
  logic [7:0]           m_wdata;
  logic                 m_wren;
  int                   m_ptr, m_w, cyc;
  ev_t                  sched[$];
  ev_t                  ev;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = '0; m_ack = '0; m_data = '0; m_addr = '0;
      m_wdata = '0; m_wren = 1'b0; m_ptr = NDR - 1;
      sched.delete();
    end else begin
      cyc++;
      m_el = drv_req & ~m_pend & ~m_ack & {NDR{~(LOAD_EN & load_active)}};
      m_w = -1;
      for (int k = 1; k <= NDR; k++) begin
        if (m_w < 0 && m_el[(m_ptr + k) % NDR]) m_w = (m_ptr + k) % NDR;
      end
      m_ack = '0;
      if (sched.size() > 0 && sched[0].due == cyc) begin
        ev = sched.pop_front();
        m_ack[ev.id]  = 1'b1;
        m_data[ev.id] = ev.data;
        m_pend[ev.id] = 1'b0;
      end
      m_wren = LOAD_EN && load_active && load_wr;
      if (m_wren) begin
        m_addr  = load_addr;
        m_wdata = load_data;
      end else if (m_w >= 0) begin
        m_addr = drv_addr[m_w];
      end
      if (m_w >= 0) begin
        m_pend[m_w] = 1'b1;
        m_ptr = m_w;
        ev.due  = cyc + RD_LAT + 1;
        ev.id   = m_w;
        ev.data = mem[drv_addr[m_w]];
        sched.push_back(ev);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ack", 32'(drv_ack), 32'(m_ack));
      for (int i = 0; i < NDR; i++) chk("cyc_data", 32'(drv_data[i]), 32'(m_data[i]));
      chk("cyc_rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("cyc_rom_wren", 32'(rom_wren), 32'(m_wren));
      chk("cyc_rom_data", 32'(rom_data), 32'(m_wdata));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(drv_ack), 32'h0);
    chk("rst_data", 32'(drv_data), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_rom_wren", 32'(rom_wren), 32'h0);
    chk("rst_rom_data", 32'(rom_data), 32'h0);
    #1 reset_n = 1'b1;
  endtask

  // Each requester drops its request in its ack cycle; bounded wait.
  task automatic drain(input int maxc);
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < NDR; i++) if (drv_req[i] && m_ack[i]) drv_req[i] = 1'b0;
      if (drv_req == '0) break;
    end
    chk("drain_done", 32'(drv_req), 32'h0);
    drv_req = '0;
  endtask

  logic [AW-1:0] ca [0:NDR-1];
  int ack_ids[$];
  int exp_fair [0:5];

  initial begin
    reset_n = 1'b1; drv_req = '0; drv_addr = '0;
    load_active = 1'b0; load_wr = 1'b0; load_addr = '0; load_data = '0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = rom_init(a);
    mem[14'h1234] = 8'hA5;
    for (int k = 0; k < RD_LAT; k++) qp[k] = 8'h00;
    cyc = 0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("init_ack", 32'(drv_ack), 32'h0);
    chk("init_rom_addr", 32'(rom_addr), 32'h0);
    #1 reset_n = 1'b1;

    // ---- single read: ack 3 edges after grant with ROM data ----
    @(negedge clk); #1 drv_addr[1] = 14'h1234; drv_req[1] = 1'b1;
    @(negedge clk);
    chk("single_rom_addr", 32'(rom_addr), 32'h1234);
    chk("single_ack_e1", 32'(drv_ack), 32'h0);
    @(negedge clk); chk("single_ack_e2", 32'(drv_ack), 32'h0);
    @(negedge clk); chk("single_ack_e3", 32'(drv_ack), 32'h0);
    @(negedge clk);
    chk("single_ack", 32'(drv_ack), 32'b0010);
    chk("single_data", 32'(drv_data[1]), 32'hA5);
    #1 drv_req[1] = 1'b0;
    @(negedge clk);
    chk("single_ack_off", 32'(drv_ack), 32'h0);
    chk("single_data_hold", 32'(drv_data[1]), 32'hA5);

    // ---- contention after reset: grants and acks 0,1,2,3 ----
    do_reset();
    for (int i = 0; i < NDR; i++) ca[i] = AW'(14'h0100 + i * 17);
    @(negedge clk); #1;
    for (int i = 0; i < NDR; i++) drv_addr[i] = ca[i];
    drv_req = '1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n <= 4) chk("cont_grant_addr", 32'(rom_addr), 32'(ca[n-1]));
      if (n >= 4) begin
        chk("cont_ack", 32'(drv_ack), 32'(1) << (n - 4));
        chk("cont_data", 32'(drv_data[n-4]), 32'(rom_init(int'(ca[n-4]))));
        #1 drv_req[n-4] = 1'b0;
      end
    end

    // ---- fairness: 0 and 2 held high alternate ----
    @(negedge clk); #1;
    drv_addr[0] = 14'h0200; drv_addr[2] = 14'h0222;
    drv_req[0] = 1'b1; drv_req[2] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDR; i++) if (drv_ack[i]) ack_ids.push_back(i);
    end
    drain(20);
    exp_fair = '{0, 2, 0, 2, 0, 2};
    for (int k = 0; k < 6; k++)
      chk("fair_order", (k < ack_ids.size()) ? 32'(ack_ids[k]) : 32'hFFFF_FFFF, 32'(exp_fair[k]));

`ifdef IEEEDRV_ROM_LOAD_EN
    // ---- download while requester 3 is in flight ----
    @(negedge clk); #1 drv_addr[3] = 14'h0333; drv_req[3] = 1'b1;
    @(negedge clk);
    chk("load_grant3_addr", 32'(rom_addr), 32'h0333);
    #1 load_active = 1'b1; drv_addr[0] = 14'h0010; drv_req[0] = 1'b1;
    @(negedge clk); #1 load_wr = 1'b1; load_addr = 14'h0010; load_data = 8'h4C;
    @(negedge clk);
    chk("load_wren", 32'(rom_wren), 32'h1);
    chk("load_rom_addr", 32'(rom_addr), 32'h0010);
    chk("load_rom_data", 32'(rom_data), 32'h4C);
    #1 load_wr = 1'b0;
    @(negedge clk);
    chk("load_ack3", 32'(drv_ack), 32'b1000);
    chk("load_wren_off", 32'(rom_wren), 32'h0);
    #1 drv_req[3] = 1'b0;
    @(negedge clk); chk("load_no_grant", 32'(drv_ack), 32'h0);
    @(negedge clk); chk("load_no_grant2", 32'(drv_ack), 32'h0);
    #1 load_active = 1'b0;
    for (int n = 7; n <= 9; n++) begin
      @(negedge clk); chk("load_resume_wait", 32'(drv_ack), 32'h0);
    end
    @(negedge clk);
    chk("load_resume_ack", 32'(drv_ack), 32'b0001);
    chk("load_resume_data", 32'(drv_data[0]), 32'h4C);
    #1 drv_req[0] = 1'b0;
`else
    // ---- load path absent: load inputs ignored, reads granted ----
    @(negedge clk); #1;
    load_active = 1'b1; load_wr = 1'b1; load_addr = 14'h0010; load_data = 8'h4C;
    drv_addr[1] = 14'h0055; drv_req[1] = 1'b1;
    @(negedge clk);
    chk("nold_wren", 32'(rom_wren), 32'h0);
    chk("nold_rom_addr", 32'(rom_addr), 32'h0055);
    chk("nold_rom_data", 32'(rom_data), 32'h0);
    #1 load_wr = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("nold_ack", 32'(drv_ack), 32'b0010);
    chk("nold_data", 32'(drv_data[1]), 32'(rom_init(16'h0055)));
    #1 drv_req[1] = 1'b0; load_active = 1'b0;
`endif

    // ---- reset mid-operation ----
    @(negedge clk); #1 drv_addr[2] = 14'h0666; drv_req[2] = 1'b1;
    @(negedge clk);
    chk("rstmid_grant_addr", 32'(rom_addr), 32'h0666);
    #1 reset_n = 1'b0; drv_req[2] = 1'b0;
    @(negedge clk);
    chk("rstmid_ack", 32'(drv_ack), 32'h0);
    chk("rstmid_data", 32'(drv_data), 32'h0);
    chk("rstmid_rom_addr", 32'(rom_addr), 32'h0);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); chk("rstmid_no_ack", 32'(drv_ack), 32'h0);
    end
    #1 drv_addr[0] = 14'h0011; drv_addr[3] = 14'h0033; drv_req[0] = 1'b1; drv_req[3] = 1'b1;
    @(negedge clk);
    chk("rstmid_first_grant", 32'(rom_addr), 32'h0011);
    drain(20);

    // ---- randomized phase ----
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < NDR; i++) begin
        if (drv_req[i]) begin
          if (m_ack[i]) begin
            if ($urandom_range(0, 1) == 0) drv_req[i] = 1'b0;
            else drv_addr[i] = AW'($urandom_range(0, 16'h1FFF));
          end
        end else if ($urandom_range(0, 3) == 0) begin
          drv_addr[i] = AW'($urandom_range(0, 16'h1FFF));
          drv_req[i]  = 1'b1;
        end
      end
      if (load_active) begin
        if ($urandom_range(0, 7) == 0) load_active = 1'b0;
      end else if ($urandom_range(0, 31) == 0) begin
        load_active = 1'b1;
      end
      load_wr   = ($urandom_range(0, 2) == 0);
      load_addr = 14'h2000 | AW'($urandom_range(0, 16'h1FFF));
      load_data = 8'($urandom);
    end
    @(negedge clk); #1 load_active = 1'b0; load_wr = 1'b0;
    drain(60);
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ieeedrv_rom_arb.md
IEEEDRV_ROM_ARB -- requirements
Module: ieeedrv_rom_arb

Interface
REQ-001 SHALL have parameter NDR, default 4, number of drive requesters (1..4).
REQ-002 SHALL have parameter ADDRWIDTH, default 14, ROM address width.
REQ-003 SHALL have parameter RD_LAT, default 2, edges from rom_addr update to valid rom_q (1..3).
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port drv_req[NDR]  in  1 each  level read request, held until ack.
REQ-007 SHALL have port drv_addr[NDR]  in  ADDRWIDTH each  read address, stable while drv_req high.
REQ-008 SHALL have port drv_ack[NDR]  out  1 each  one-cycle pulse, data valid.
REQ-009 SHALL have port drv_data[NDR]  out  8 each  registered read data, held until next ack to that requester.
REQ-010 SHALL have port load_active  in  1  ROM download in progress; blocks reads.
REQ-011 SHALL have port load_wr  in  1  one-cycle write strobe.
REQ-012 SHALL have ports load_addr  in  ADDRWIDTH and load_data  in  8  write address/data.
REQ-013 SHALL have ports rom_addr  out  ADDRWIDTH, rom_data  out  8, rom_wren  out  1, rom_q  in  8  to the single-port ROM.

Function
REQ-014 SHALL sample each eligible request at every edge, where eligible = drv_req & ~pending & ~drv_ack & ~load_active.
REQ-015 SHALL grant at most one requester per edge, round-robin: search starts at last winner+1 mod NDR, and the pointer becomes the winner.
REQ-016 SHALL, on the grant edge E, register rom_addr<=drv_addr[winner], set pending[winner], and push {valid,id} into a RD_LAT+1-deep tag pipeline.
REQ-017 SHALL, at edge E+RD_LAT+1, register drv_data[id]<=rom_q, pulse drv_ack[id] for exactly one cycle, and clear pending[id].
REQ-018 SHALL sustain one grant per cycle with up to NDR reads in flight; back-to-back grants to different requesters SHALL be acked in grant order.
REQ-019 SHALL hold rom_addr unchanged in cycles with no grant or write.
REQ-020 SHALL keep a requester ineligible in its ack cycle; a requester holding drv_req high after ack SHALL be re-granted at the following edge with its current address.
REQ-021 SHALL keep the grant at which load_active rises, and grant no reads while load_active is high; in-flight reads SHALL still complete and ack.
REQ-022 SHALL, on load_wr high while load_active is high, drive rom_addr<=load_addr, rom_data<=load_data, rom_wren<=1 for exactly one cycle; load_wr with load_active low SHALL be ignored.
REQ-023 SHALL ignore drv_req of indexes >= NDR; drv_ack/drv_data for such indexes SHALL be 0.

Reset
REQ-024 SHALL, on reset_n low, immediately clear drv_ack, drv_data, rom_addr, rom_data, rom_wren, pending and the tag pipeline, and set the RR pointer to NDR-1 so requester 0 has first priority.
REQ-025 SHALL drop reads in flight at reset with no ack issued after reset release.

Configuration
REQ-026 SHALL compile the load path only when IEEEDRV_ROM_LOAD_EN is defined; without it, load_* inputs SHALL be ignored, rom_wren and rom_data SHALL be constant 0, and load_active SHALL not block reads.

Verification
REQ-027 Single read: RD_LAT=2, drv_req[1]=1, addr 0x1234, model returns 0xA5 -> drv_ack[1] one cycle, 3 edges after grant, drv_data[1]=0xA5.
REQ-028 Contention: all 4 requesters raise req same cycle after reset -> grants in order 0,1,2,3 on consecutive edges, acks in order 0,1,2,3 on consecutive edges.
REQ-029 Fairness: requesters 0 and 2 keep req high continuously -> grants alternate 0,2,0,2; neither waits more than 2 grant slots.
REQ-030 Load: load_active=1 while req[3] pending, then load_wr with 0x0010/0x4C -> req[3] acks the in-flight read, no new grant, rom_wren=1 one cycle with rom_addr 0x0010, rom_data 0x4C; after load_active=0 grants resume.
REQ-031 Reset mid-operation: reset_n low one cycle after grant to requester 2 -> all outputs 0, no drv_ack[2] after release; requester 0 wins first post-reset grant.
REQ-032 Macro off: without IEEEDRV_ROM_LOAD_EN, load_active=1 and load_wr pulses -> rom_wren stays 0, reads continue to be granted.
